conv_egress: RTL
================

// Module: conv_egress
// PURPOSE
//  AXI4-Stream transmitter at the output end of the convolution engine. Accepts
//  one filtered pixel/cycle with its kernel position (conv_pkg::kernel_pos_t),
//  regenerates SOF (tuser) / EOL (tlast), buffers in-flight results so m_tready
//  back-pressure never drops data, and checks frame framing/geometry.
// PARAMETERS
//  DEPTH     8   result FIFO entries (power of 2, >= 4)
//  AF_SLACK  4   free entries kept in reserve; covers upstream pipeline latency
//  CNT_W     12  width of column counter / learned line width
// PORTS
//  clk          in   1        clock
//  arst_n       in   1        async reset, active-low
//  res_vld_i    in   1        result pixel valid (no ready; always accepted)
//  res_pos_i    in   $bits(kernel_pos_t)  position flags of result pixel
//  res_data_i   in   PIXEL_W  filtered pixel
//  cntrl_rdy_o  out  1        space-available; drives upstream m_tready_i
//  m_tvalid_o   out  1        AXIS valid
//  m_tdata_o    out  PIXEL_W  AXIS data
//  m_tuser_o    out  1        SOF: first pixel of frame
//  m_tlast_o    out  1        EOL: last pixel of line
//  m_tready_i   in   1        AXIS ready
//  frame_done_o out  1        1-cycle pulse when last pixel of frame is sent
//  err_o        out  3        sticky {len_mismatch, sof_in_frame, overflow}
//  err_clr_i    in   1        clears err_o (next cycle)
// BEHAVIOUR
//  Reset: m_tvalid_o=0, m_tuser_o=0, m_tlast_o=0, cntrl_rdy_o=1, frame_done_o=0,
//   err_o=0, FIFO empty, FSM=IDLE, counters=0. m_tdata_o don't-care while !valid.
//  Beat mapping: sof=n2&w2, eol=e2, eof=e2&s2; stored as conv_pkg::egress_beat_t.
//  FIFO: push on res_vld_i; pop on m_tvalid_o&m_tready_i. No bypass: push to
//   empty FIFO -> m_tvalid_o=1 next cycle (latency 1). Push+pop same cycle when
//   full is legal, count unchanged. Push when full without pop: beat dropped,
//   err_o[0] set. Head beat/flags held stable while m_tvalid_o&!m_tready_i.
//  cntrl_rdy_o registered: 1 iff (count_next <= DEPTH-AF_SLACK).
//  Framing FSM (advances on accepted push):
//   IDLE : sof -> FRAME0 (col=1). non-sof beat forwarded, no error.
//   FRAME0 (first line): col++; on eol latch width=col, col=0 -> FRAMEN;
//     eol&eof (single-line frame) -> IDLE.
//   FRAMEN: col++; on eol, col!=width -> err_o[2]; eof -> IDLE.
//   Any state != IDLE with sof: err_o[1] set, restart at FRAME0 (col=1).
//   Single-pixel line (sof&eol&eof same beat): width=1, stay IDLE.
//  frame_done_o: pulse in cycle the eof beat is popped (handshake cycle).
//  Counters wrap at 2**CNT_W silently (not an error).
//  err_clr_i coincident with new error: new error wins (stays set).
//  Reset mid-frame/mid-burst: FIFO contents discarded, m_tvalid_o drops
//   immediately (async), FSM to IDLE; no partial frame_done_o.
// STRUCTURE
//  conv_pkg: egress_beat_t {sof,eol,eof,pixel_t dat}; egress_err_t (3b) enum
//   bit indices; EGRESS_ERR_W.
//  Sub-module conv_egress_fifo: sync FIFO (DEPTH, W=$bits(egress_beat_t)),
//   push/pop/full/empty/count; flops via flops.svh (dffr/dffre).
//  Top: beat encode, FSM + col/width counters, rdy/err/done registers.
// TESTING
//  1. 4x3 frame, m_tready_i=1 -> 12 beats, tuser on beat0 only, tlast on beats
//     3/7/11, frame_done_o pulses with beat 11, err_o=0.
//  2. Same frame, m_tready_i toggling 1,0,0,1 -> identical beat sequence, data
//     stable while stalled, cntrl_rdy_o=0 when count>4.
//  3. m_tready_i=0, 9 pushes (DEPTH=8) -> 9th dropped, err_o=3'b001; err_clr_i
//     -> err_o=0 next cycle.
//  4. Line lengths 4,3,4 -> err_o[2] set at 2nd eol; output still forwards all.
//  5. sof mid-frame (beat 5) -> err_o[1] set, col restarts, later 4-wide lines OK.
//  6. arst_n low with 5 beats buffered -> m_tvalid_o=0, cntrl_rdy_o=1, then a
//     clean 2x2 frame passes with frame_done_o on beat 3.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types for the convolution engine egress path: kernel position flags,
// the buffered egress beat, error bit indices and framing FSM states.
package conv_pkg;

  localparam int PIXEL_W      = 8;
  localparam int EGRESS_ERR_W = 3;

  typedef logic [PIXEL_W-1:0] pixel_t;

  // Border flags of the kernel centre: first row, last row, first col, last col.
  typedef struct packed {
    logic n2;
    logic s2;
    logic w2;
    logic e2;
  } kernel_pos_t;

  typedef struct packed {
    logic   sof;
    logic   eol;
    logic   eof;
    pixel_t dat;
  } egress_beat_t;

  typedef enum logic [1:0] {
    ERR_OVERFLOW     = 2'd0,
    ERR_SOF_IN_FRAME = 2'd1,
    ERR_LEN_MISMATCH = 2'd2
  } egress_err_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FRAME0 = 2'd1,
    ST_FRAMEN = 2'd2
  } egress_state_t;

  function automatic egress_beat_t encode_beat(kernel_pos_t pos, pixel_t dat);
    egress_beat_t b;
    b.sof = pos.n2 & pos.w2;
    b.eol = pos.e2;
    b.eof = pos.e2 & pos.s2;
    b.dat = dat;
    return b;
  endfunction

endpackage

// File: rtl/conv_egress_fifo.sv
// Synchronous FIFO with combinational head read; a push when full is only
// accepted if a pop happens in the same cycle, otherwise the beat is discarded.
module conv_egress_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             wdata_i,
  output logic [W-1:0]             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (!do_push && do_pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset: contents are meaningless while count is zero.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/conv_egress.sv
// AXI4-Stream egress of the convolution engine: encodes SOF/EOL/EOF from kernel
// position, buffers beats against back-pressure and checks frame geometry.
module conv_egress
  import conv_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int AF_SLACK = 4,
  parameter int CNT_W    = 12
) (
  input  logic                        clk,
  input  logic                        arst_n,
  input  logic                        res_vld_i,
  input  logic [$bits(kernel_pos_t)-1:0] res_pos_i,
  input  logic [PIXEL_W-1:0]          res_data_i,
  output logic                        cntrl_rdy_o,
  output logic                        m_tvalid_o,
  output logic [PIXEL_W-1:0]          m_tdata_o,
  output logic                        m_tuser_o,
  output logic                        m_tlast_o,
  input  logic                        m_tready_i,
  output logic                        frame_done_o,
  output logic [EGRESS_ERR_W-1:0]     err_o,
  input  logic                        err_clr_i
);

  localparam int CW = $clog2(DEPTH) + 1;

  egress_beat_t  in_beat, head_beat;
  logic [$bits(egress_beat_t)-1:0] head_raw;
  logic          fifo_full, fifo_empty, pop, acc, drop;
  logic [CW-1:0] count, count_next;

  egress_state_t            state_q;
  logic [CNT_W-1:0]         col_q, width_q, col_inc;
  logic                     rdy_q;
  logic [EGRESS_ERR_W-1:0]  err_q, err_set;

  assign in_beat = encode_beat(kernel_pos_t'(res_pos_i), res_data_i);

  conv_egress_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(egress_beat_t))
  ) u_fifo (
    .clk     (clk),
    .arst_n  (arst_n),
    .push_i  (res_vld_i),
    .pop_i   (pop),
    .wdata_i (in_beat),
    .rdata_o (head_raw),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count)
  );

  assign head_beat    = egress_beat_t'(head_raw);
  assign m_tvalid_o   = ~fifo_empty;
  assign pop          = m_tvalid_o & m_tready_i;
  assign m_tdata_o    = head_beat.dat;
  assign m_tuser_o    = m_tvalid_o & head_beat.sof;
  assign m_tlast_o    = m_tvalid_o & head_beat.eol;
  assign frame_done_o = pop & head_beat.eof;

  assign drop = res_vld_i & fifo_full & ~pop;
  assign acc  = res_vld_i & ~drop;

  always_comb begin
    count_next = count;
    if (acc && !pop)      count_next = count + CW'(1);
    else if (!acc && pop) count_next = count - CW'(1);
  end

  assign col_inc = col_q + CNT_W'(1);

  always_comb begin
    err_set = '0;
    err_set[ERR_OVERFLOW] = drop;
    if (acc && in_beat.sof && state_q != ST_IDLE)
      err_set[ERR_SOF_IN_FRAME] = 1'b1;
    if (acc && !in_beat.sof && state_q == ST_FRAMEN && in_beat.eol && col_inc != width_q)
      err_set[ERR_LEN_MISMATCH] = 1'b1;
  end

  assign cntrl_rdy_o = rdy_q;
  assign err_o       = err_q;

  // A new error outranks a coincident clear so no event is ever lost.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rdy_q <= 1'b1;
      err_q <= '0;
    end else begin
      rdy_q <= (count_next <= CW'(DEPTH - AF_SLACK));
      err_q <= (err_clr_i ? '0 : err_q) | err_set;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      width_q <= '0;
    end else if (acc) begin
      if (in_beat.sof) begin
        if (in_beat.eol) begin
          width_q <= CNT_W'(1);
          col_q   <= '0;
          state_q <= in_beat.eof ? ST_IDLE : ST_FRAMEN;
        end else begin
          col_q   <= CNT_W'(1);
          state_q <= ST_FRAME0;
        end
      end else begin
        unique case (state_q)
          ST_FRAME0: begin
            if (in_beat.eol) begin
              width_q <= col_inc;
              col_q   <= '0;
              state_q <= in_beat.eof ? ST_IDLE : ST_FRAMEN;
            end else begin
              col_q <= col_inc;
            end
          end
          ST_FRAMEN: begin
            if (in_beat.eol) begin
              col_q <= '0;
              if (in_beat.eof) state_q <= ST_IDLE;
            end else begin
              col_q <= col_inc;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
